// File: rtl/pcie_route_fabric_pkg.sv
// Shared definitions for the PCIe route fabric: route decision type,
// drop-counter width and the destination-field width helper.
package pcie_route_fabric_pkg;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ROUTE_IDLE = 2'd0,
        ROUTE_PUSH = 2'd1,
        ROUTE_BAD  = 2'd2
    } route_kind_e;

    // Destination field is never narrower than one bit, even for two channels.
    function automatic int dest_bits(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcie_route_fabric_route_fifo.sv
// route_fifo: single-channel synchronous FIFO with count-derived status flags
// and a registered head-of-queue output that pulses valid for one cycle.
module route_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AF    = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic [W-1:0]  mem_r [DEPTH];
    logic [W-1:0]  dout_r;
    logic          dout_valid_r;
    logic          wr_en_s;
    logic          rd_en_s;

    assign full        = (count_r == (PW+1)'(DEPTH));
    assign empty       = (count_r == (PW+1)'(0));
    assign almost_full = (count_r >= (PW+1)'(AF));
    assign wr_en_s     = push & ~full;
    assign rd_en_s     = pop & ~empty;
    // A push against a full FIFO is lost even if a pop frees a slot this cycle.
    assign overflow    = push & full;
    assign dout        = dout_r;
    assign dout_valid  = dout_valid_r;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy count and registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= rd_en_s;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
                dout_r   <= mem_r[rd_ptr_r];
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pcie_route_fabric.sv
// pcie_route_fabric: routes tagged words into NUM_CH channel FIFOs with sticky
// error flags. Define ROUTE_STATS_EN to enable per-channel drop counters.
module pcie_route_fabric
    import pcie_route_fabric_pkg::*;
#(
    parameter  int MAIN_SIZE  = 8,
    parameter  int NUM_CH     = 4,
    parameter  int FIFO_DEPTH = 4,
    parameter  int AF_THRESH  = 3,
    localparam int DEST_BITS  = dest_bits(NUM_CH),
    localparam int DATA_SIZE  = MAIN_SIZE + DEST_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_SIZE-1:0]           in,
    input  logic                           valid,
    input  logic [NUM_CH-1:0]              pop,
    input  logic                           err_clr,
    output logic [NUM_CH*MAIN_SIZE-1:0]    out,
    output logic [NUM_CH-1:0]              out_valid,
    output logic [NUM_CH-1:0]              almost_full,
    output logic [NUM_CH-1:0]              empty,
    output logic                           err_route,
    output logic                           err_overflow,
    output logic [NUM_CH*DROP_CNT_W-1:0]   drop_cnt
);

    logic [DEST_BITS-1:0] dest_s;
    logic [MAIN_SIZE-1:0] payload_s;
    route_kind_e          route_kind_s;
    logic [NUM_CH-1:0]    push_s;
    logic [NUM_CH-1:0]    full_s;
    logic [NUM_CH-1:0]    ovf_s;
    logic                 err_route_r;
    logic                 err_overflow_r;

    assign dest_s       = in[DATA_SIZE-1:MAIN_SIZE];
    assign payload_s    = in[MAIN_SIZE-1:0];
    assign err_route    = err_route_r;
    assign err_overflow = err_overflow_r;

    // Classify the incoming word; the extra bit keeps NUM_CH representable.
    always_comb begin
        route_kind_s = ROUTE_IDLE;
        if (valid) begin
            if ({1'b0, dest_s} >= (DEST_BITS+1)'(NUM_CH)) begin
                route_kind_s = ROUTE_BAD;
            end else begin
                route_kind_s = ROUTE_PUSH;
            end
        end else begin
            route_kind_s = ROUTE_IDLE;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign push_s[i] = (route_kind_s == ROUTE_PUSH) &&
                           ({1'b0, dest_s} == (DEST_BITS+1)'(i));

        route_fifo #(
            .W     (MAIN_SIZE),
            .DEPTH (FIFO_DEPTH),
            .AF    (AF_THRESH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push        (push_s[i]),
            .pop         (pop[i]),
            .din         (payload_s),
            .dout        (out[i*MAIN_SIZE +: MAIN_SIZE]),
            .dout_valid  (out_valid[i]),
            .full        (full_s[i]),
            .empty       (empty[i]),
            .almost_full (almost_full[i]),
            .overflow    (ovf_s[i])
        );

`ifdef ROUTE_STATS_EN
        logic [DROP_CNT_W-1:0] drop_cnt_r;

        // Saturating count of words lost to a full FIFO; cleared only by reset.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                drop_cnt_r <= '0;
            end else if (ovf_s[i] && (drop_cnt_r != DROP_CNT_MAX)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end

        assign drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_r;
`else
        assign drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = 8'h00;
`endif
    end

    // Sticky error flags; a fresh event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_route_r    <= 1'b0;
            err_overflow_r <= 1'b0;
        end else begin
            if (route_kind_s == ROUTE_BAD) begin
                err_route_r <= 1'b1;
            end else if (err_clr) begin
                err_route_r <= 1'b0;
            end else begin
                err_route_r <= err_route_r;
            end
            if (|ovf_s) begin
                err_overflow_r <= 1'b1;
            end else if (err_clr) begin
                err_overflow_r <= 1'b0;
            end else begin
                err_overflow_r <= err_overflow_r;
            end
        end
    end

endmodule

// File: tb/tb_pcie_route_fabric.sv
// Directed bench for pcie_route_fabric: vector table for the main flow plus
// hand sequences for wrap ordering, saturation, bad routing and async reset.
module tb_pcie_route_fabric;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  din;
    logic        valid;
    logic [3:0]  pop;
    logic        err_clr;
    logic [31:0] out;
    logic [3:0]  out_valid, almost_full, empty;
    logic        err_route, err_overflow;
    logic [31:0] drop_cnt;

    logic [9:0]  din3;
    logic        valid3;
    logic [2:0]  pop3;
    logic        err_clr3;
    logic [23:0] out3;
    logic [2:0]  out_valid3, almost_full3, empty3;
    logic        err_route3, err_overflow3;
    logic [23:0] drop_cnt3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pcie_route_fabric dut (
        .clk(clk), .reset(reset), .in(din), .valid(valid), .pop(pop),
        .err_clr(err_clr), .out(out), .out_valid(out_valid),
        .almost_full(almost_full), .empty(empty), .err_route(err_route),
        .err_overflow(err_overflow), .drop_cnt(drop_cnt)
    );

    pcie_route_fabric #(.NUM_CH(3)) dut3 (
        .clk(clk), .reset(reset), .in(din3), .valid(valid3), .pop(pop3),
        .err_clr(err_clr3), .out(out3), .out_valid(out_valid3),
        .almost_full(almost_full3), .empty(empty3), .err_route(err_route3),
        .err_overflow(err_overflow3), .drop_cnt(drop_cnt3)
    );

    typedef struct {
        logic        valid;
        logic [9:0]  din;
        logic [3:0]  pop;
        logic        clr;
        logic [3:0]  exp_ov;
        logic [31:0] exp_out;
        logic [3:0]  exp_empty;
        logic [3:0]  exp_af;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out"},       out,              32'h0);
        check({tag, " out_valid"}, {28'h0, out_valid}, 32'h0);
        check({tag, " empty"},     {28'h0, empty},     32'hF);
        check({tag, " af"},        {28'h0, almost_full}, 32'h0);
        check({tag, " errs"},      {30'h0, err_route, err_overflow}, 32'h0);
        check({tag, " drop_cnt"},  drop_cnt,         32'h0);
    endtask

    logic [7:0] q [$];
    logic [7:0] exp_b;
    logic [31:0] exp_drop;

    initial begin
        reset = 1'b0; din = 10'h0; valid = 1'b0; pop = 4'h0; err_clr = 1'b0;
        din3 = 10'h0; valid3 = 1'b0; pop3 = 3'h0; err_clr3 = 1'b0;

        tbl[0]  = '{1'b1, 10'h2A5, 4'h0, 1'b0, 4'h0, 32'h00000000, 4'hB, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 10'h000, 4'h4, 1'b0, 4'h4, 32'h00A50000, 4'hF, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 10'h000, 4'h0, 1'b0, 4'h0, 32'h00A50000, 4'hF, 4'h0, 1'b0};
        tbl[3]  = '{1'b1, 10'h111, 4'h0, 1'b0, 4'h0, 32'h00A50000, 4'hD, 4'h0, 1'b0};
        tbl[4]  = '{1'b1, 10'h122, 4'h0, 1'b0, 4'h0, 32'h00A50000, 4'hD, 4'h0, 1'b0};
        tbl[5]  = '{1'b1, 10'h133, 4'h0, 1'b0, 4'h0, 32'h00A50000, 4'hD, 4'h2, 1'b0};
        tbl[6]  = '{1'b1, 10'h144, 4'h0, 1'b0, 4'h0, 32'h00A50000, 4'hD, 4'h2, 1'b0};
        tbl[7]  = '{1'b1, 10'h155, 4'h0, 1'b0, 4'h0, 32'h00A50000, 4'hD, 4'h2, 1'b1};
        tbl[8]  = '{1'b0, 10'h000, 4'h2, 1'b0, 4'h2, 32'h00A51100, 4'hD, 4'h2, 1'b1};
        tbl[9]  = '{1'b0, 10'h000, 4'h2, 1'b1, 4'h2, 32'h00A52200, 4'hD, 4'h0, 1'b0};
        tbl[10] = '{1'b1, 10'h066, 4'h2, 1'b0, 4'h2, 32'h00A53300, 4'hC, 4'h0, 1'b0};
        tbl[11] = '{1'b0, 10'h000, 4'h3, 1'b0, 4'h3, 32'h00A54466, 4'hF, 4'h0, 1'b0};
        tbl[12] = '{1'b0, 10'h000, 4'h8, 1'b0, 4'h0, 32'h00A54466, 4'hF, 4'h0, 1'b0};

        #12;
        check_reset_state("init");
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            valid = tbl[i].valid; din = tbl[i].din; pop = tbl[i].pop; err_clr = tbl[i].clr;
            step();
            check($sformatf("v%0d out_valid", i), {28'h0, out_valid}, {28'h0, tbl[i].exp_ov});
            check($sformatf("v%0d out", i), out, tbl[i].exp_out);
            check($sformatf("v%0d empty", i), {28'h0, empty}, {28'h0, tbl[i].exp_empty});
            check($sformatf("v%0d af", i), {28'h0, almost_full}, {28'h0, tbl[i].exp_af});
            check($sformatf("v%0d err_ovf", i), {31'h0, err_overflow}, {31'h0, tbl[i].exp_ovf});
            check($sformatf("v%0d err_route", i), {31'h0, err_route}, 32'h0);
        end
        valid = 1'b0; pop = 4'h0; err_clr = 1'b0;

`ifdef ROUTE_STATS_EN
        exp_drop = 32'h00000100;
`else
        exp_drop = 32'h00000000;
`endif
        check("ch1 drop_cnt", drop_cnt, exp_drop);

        // Ordering across pointer wrap with simultaneous push and pop on ch0.
        valid = 1'b1; din = 10'h0A0; step();
        din = 10'h0A1; step();
        q.push_back(8'hA0); q.push_back(8'hA1);
        for (int k = 0; k < 10; k++) begin
            din = {2'b00, 8'hB0 + 8'(k)}; pop = 4'h1;
            step();
            exp_b = q.pop_front();
            q.push_back(8'hB0 + 8'(k));
            check($sformatf("wrap%0d data", k), {24'h0, out[7:0]}, {24'h0, exp_b});
            check($sformatf("wrap%0d ov0", k), {31'h0, out_valid[0]}, 32'h1);
            check($sformatf("wrap%0d empty", k), {28'h0, empty}, 32'hE);
            check($sformatf("wrap%0d af", k), {28'h0, almost_full}, 32'h0);
        end
        valid = 1'b0; pop = 4'h0;

        // Saturation of the ch3 drop counter.
        for (int k = 0; k < 304; k++) begin
            valid = 1'b1; din = 10'h3C0;
            step();
        end
        valid = 1'b0;
`ifdef ROUTE_STATS_EN
        exp_drop = 32'hFF000100;
`else
        exp_drop = 32'h00000000;
`endif
        check("ch3 drop_cnt sat", drop_cnt, exp_drop);
        check("ch3 ovf", {31'h0, err_overflow}, 32'h1);
        check("ch3 af", {28'h0, almost_full}, 32'h8);

        // Bad route on the three-channel variant.
        valid3 = 1'b1; din3 = 10'h3FF; step();
        check("nc3 err_route", {31'h0, err_route3}, 32'h1);
        check("nc3 empty", {29'h0, empty3}, 32'h7);
        valid3 = 1'b1; err_clr3 = 1'b1; step();
        check("nc3 err over clr", {31'h0, err_route3}, 32'h1);
        valid3 = 1'b0; step();
        check("nc3 err cleared", {31'h0, err_route3}, 32'h0);
        err_clr3 = 1'b0;
        check("nc3 no ovf", {31'h0, err_overflow3}, 32'h0);

        // Asynchronous reset in the middle of traffic.
        valid = 1'b1; din = 10'h2AA; pop = 4'h9;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_reset_state("midrst");
        valid = 1'b0; pop = 4'h0;
        step();
        reset = 1'b1;
        step();
        check("post rst empty", {28'h0, empty}, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
